// File: rtl/part_f_pkg.sv
// Shared CPU constants and types for the fetch stage and its F/D pipeline register.
package part_f_pkg;

  // Machine word width used by PCs and instructions.
  localparam int WORD_W = 32;

  // First fetch address after reset.
  localparam logic [WORD_W-1:0] PC_RESET = 32'h0000_3000;

  // Instruction memory depth in 32-bit words.
  localparam int IM_WORDS = 4096;

  // Encoding used for bubbles and for instructions replaced on a fetch error.
  localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/part_f_pipe_fd.sv
// F/D pipeline register: instruction, PC, valid bit and fetch address-error flag.
// clear loads a bubble (carrying fetch_pc) and wins over hold; hold keeps the entry.
module pipe_fd
  import part_f_pkg::*;
#(
  parameter word_t RESET_PC = part_f_pkg::PC_RESET
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  hold,
  input  logic  clear,
  input  word_t fetch_instr,
  input  word_t fetch_pc,
  input  logic  fetch_exc,
  output word_t dec_instr,
  output word_t dec_pc,
  output logic  dec_valid,
  output logic  dec_exc
);

  // Entry update: bubble on clear, keep on hold, otherwise capture the fetched entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_instr <= NOP;
      dec_pc    <= RESET_PC;
      dec_valid <= 1'b0;
      dec_exc   <= 1'b0;
    end else if (clear) begin
      dec_instr <= NOP;
      dec_pc    <= fetch_pc;
      dec_valid <= 1'b0;
      dec_exc   <= 1'b0;
    end else if (!hold) begin
      dec_instr <= fetch_instr;
      dec_pc    <= fetch_pc;
      dec_valid <= 1'b1;
      dec_exc   <= fetch_exc;
    end
  end

endmodule

// File: rtl/part_f.sv
// Fetch stage: PC register, next-PC selection, fetch address checking and the
// F/D register. The instruction memory is external and read combinationally
// at IM_addr; its data only reaches outputs through the F/D register.
module part_f
  import part_f_pkg::*;
#(
  parameter word_t PC_RESET = part_f_pkg::PC_RESET,
  parameter int    IM_WORDS = part_f_pkg::IM_WORDS
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        FlushD,
  input  logic        isjump,
  input  logic [31:0] NPC,
  output logic [31:0] IM_addr,
  input  logic [31:0] IM_rdata,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC4D,
  output logic        V_D,
  output logic        ExcAdEL_D,
  output logic [31:0] StallCnt
);

  // One past the last valid fetch address, kept 33 bits wide so it cannot wrap.
  localparam logic [WORD_W:0] PC_LIMIT =
    {1'b0, PC_RESET} + ({1'b0, 32'(IM_WORDS)} << 2);

  word_t pc_next;
  word_t fetch_instr;
  logic  fetch_err;

  // Next PC: hold on stall, otherwise the decode-selected target or sequential.
  always_comb begin
    pc_next = PC_F + 32'd4;
    if (Stall) begin
      pc_next = PC_F;
    end else if (isjump) begin
      pc_next = NPC;
    end
  end

  // Fetch address error: misaligned or outside the instruction memory window.
  always_comb begin
    fetch_err   = (PC_F[1:0] != 2'b00) ||
                  (PC_F < PC_RESET) ||
                  ({1'b0, PC_F} >= PC_LIMIT);
    fetch_instr = fetch_err ? NOP : IM_rdata;
  end

  // PC register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      PC_F <= PC_RESET;
    end else begin
      PC_F <= pc_next;
    end
  end

  // Stalled-cycle counter, saturating at all ones.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      StallCnt <= '0;
    end else if (Stall && (StallCnt != 32'hFFFF_FFFF)) begin
      StallCnt <= StallCnt + 32'd1;
    end
  end

  pipe_fd #(
    .RESET_PC (PC_RESET)
  ) u_pipe_fd (
    .clk         (Clk),
    .rst_n       (Reset),
    .hold        (Stall),
    .clear       (FlushD),
    .fetch_instr (fetch_instr),
    .fetch_pc    (PC_F),
    .fetch_exc   (fetch_err),
    .dec_instr   (Instr_D),
    .dec_pc      (PC_D),
    .dec_valid   (V_D),
    .dec_exc     (ExcAdEL_D)
  );

  assign IM_addr = PC_F;
  assign PC4D    = PC_D + 32'd4;

endmodule

// File: tb/tb_part_f.sv
// Bench for part_f: behavioural instruction memory, reference model of the
// fetch stage feeding an expected queue, and a single comparison task.
module tb_part_f;

  localparam int W = 130;  // {instr, pc_d, pc_f, stall_cnt, v, exc}

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        FlushD;
  logic        isjump;
  logic [31:0] NPC;
  logic [31:0] IM_addr;
  logic [31:0] IM_rdata;
  logic [31:0] PC_F;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC4D;
  logic        V_D;
  logic        ExcAdEL_D;
  logic [31:0] StallCnt;

  int checks;
  int failures;

  logic [W-1:0] exp_q[$];

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic        m_v;
  logic        m_exc;
  logic [31:0] m_cnt;

  part_f dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Stall     (Stall),
    .FlushD    (FlushD),
    .isjump    (isjump),
    .NPC       (NPC),
    .IM_addr   (IM_addr),
    .IM_rdata  (IM_rdata),
    .PC_F      (PC_F),
    .Instr_D   (Instr_D),
    .PC_D      (PC_D),
    .PC4D      (PC4D),
    .V_D       (V_D),
    .ExcAdEL_D (ExcAdEL_D),
    .StallCnt  (StallCnt)
  );

  // Clock / reset block.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Memory contents: a fixed word at 0x3000, an address-derived pattern
  // elsewhere, and junk for anything the memory would not decode.
  function automatic logic [31:0] im_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2408_0001;
    if (a[1:0] != 2'b00 || a < 32'h0000_3000 || a >= 32'h0000_7000)
      return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  always_comb IM_rdata = im_word(IM_addr);

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0000_3000;
    m_instr = 32'h0;
    m_pcd   = 32'h0000_3000;
    m_v     = 1'b0;
    m_exc   = 1'b0;
    m_cnt   = 32'h0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_pc_f"},  PC_F,      32'h0000_3000);
    check_eq({tag, "_instr"}, Instr_D,   32'h0);
    check_eq({tag, "_pc_d"},  PC_D,      32'h0000_3000);
    check_eq({tag, "_pc4d"},  PC4D,      32'h0000_3004);
    check_eq({tag, "_v"},     {31'b0, V_D},       32'h0);
    check_eq({tag, "_exc"},   {31'b0, ExcAdEL_D}, 32'h0);
    check_eq({tag, "_cnt"},   StallCnt,  32'h0);
  endtask

  // Driver: apply one cycle of controls, push the model's expectation, let the
  // edge happen, then pop and compare.
  task automatic step(input string tag, input logic st, input logic fl,
                      input logic jp, input logic [31:0] npc);
    logic          e;
    logic [W-1:0]  exp;
    logic [W-1:0]  got;
    Stall  = st;
    FlushD = fl;
    isjump = jp;
    NPC    = npc;
    e = addr_bad(m_pc);
    if (fl) begin
      m_instr = 32'h0; m_pcd = m_pc; m_v = 1'b0; m_exc = 1'b0;
    end else if (!st) begin
      m_instr = e ? 32'h0 : im_word(m_pc); m_pcd = m_pc; m_v = 1'b1; m_exc = e;
    end
    if (st) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m_pc = jp ? npc : m_pc + 32'd4;
    end
    exp_q.push_back({m_instr, m_pcd, m_pc, m_cnt, m_v, m_exc});
    @(posedge Clk);
    #1;
    exp = exp_q.pop_front();
    got = {Instr_D, PC_D, PC_F, StallCnt, V_D, ExcAdEL_D};
    check_eq({tag, "_instr"}, got[129:98], exp[129:98]);
    check_eq({tag, "_pc_d"},  got[97:66],  exp[97:66]);
    check_eq({tag, "_pc_f"},  got[65:34],  exp[65:34]);
    check_eq({tag, "_cnt"},   got[33:2],   exp[33:2]);
    check_eq({tag, "_v"},     {31'b0, got[1]}, {31'b0, exp[1]});
    check_eq({tag, "_exc"},   {31'b0, got[0]}, {31'b0, exp[0]});
    check_eq({tag, "_pc4d"},  PC4D,    exp[97:66] + 32'd4);
    check_eq({tag, "_imaddr"}, IM_addr, exp[65:34]);
  endtask

  initial begin
    logic [31:0] held_instr;
    checks   = 0;
    failures = 0;
    Reset  = 1'b0;
    Stall  = 1'b0;
    FlushD = 1'b0;
    isjump = 1'b0;
    NPC    = 32'h0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_reset_values("rst");
    Reset = 1'b1;

    // Sequential fetch out of reset.
    step("seq0", 0, 0, 0, 32'h0);
    check_eq("seq0_first_instr", Instr_D, 32'h2408_0001);
    check_eq("seq0_first_pcf",   PC_F,    32'h0000_3004);
    step("seq1", 0, 0, 0, 32'h0);

    // Jump at 0x3008: delay slot kept, PC redirected.
    step("jmp", 0, 0, 1, 32'h0000_3100);
    check_eq("jmp_slot_pcd", PC_D, 32'h0000_3008);
    check_eq("jmp_target",   PC_F, 32'h0000_3100);
    step("jmp2", 0, 0, 1, 32'h0000_3010);

    // Three stall cycles at 0x3010, with a jump request that must be ignored.
    held_instr = Instr_D;
    step("stall0", 1, 0, 0, 32'h0);
    step("stall1", 1, 0, 1, 32'h0000_3500);
    step("stall2", 1, 0, 0, 32'h0);
    check_eq("stall_pcf",   PC_F,     32'h0000_3010);
    check_eq("stall_instr", Instr_D,  held_instr);
    check_eq("stall_cnt",   StallCnt, 32'd3);

    // Flush together with stall: bubble in F/D, PC held.
    step("flush_stall", 1, 1, 0, 32'h0);
    check_eq("flush_instr", Instr_D, 32'h0);
    check_eq("flush_v",     {31'b0, V_D}, 32'h0);
    check_eq("flush_pcf",   PC_F, 32'h0000_3010);
    step("resume", 0, 0, 0, 32'h0);

    // Address errors: misaligned, below the window, and the upper boundary.
    step("to3002", 0, 0, 1, 32'h0000_3002);
    step("err3002", 0, 0, 1, 32'h0000_2FFC);
    check_eq("err3002_exc", {31'b0, ExcAdEL_D}, 32'h1);
    step("err2ffc", 0, 0, 1, 32'h0000_6FFC);
    check_eq("err2ffc_exc", {31'b0, ExcAdEL_D}, 32'h1);
    step("last_ok", 0, 0, 0, 32'h0);
    check_eq("last_ok_exc", {31'b0, ExcAdEL_D}, 32'h0);
    step("past_end", 0, 0, 0, 32'h0);
    check_eq("past_end_exc", {31'b0, ExcAdEL_D}, 32'h1);
    step("back", 0, 0, 1, 32'h0000_3020);
    step("back1", 0, 0, 0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] tgt;
      tgt = 32'h0000_3000 + ($urandom_range(0, 4095) << 2);
      if ($urandom_range(0, 7) == 0) tgt = tgt + 32'($urandom_range(1, 3));
      step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), tgt);
    end

    // Asynchronous reset between edges, mid-stall with a pending jump.
    Stall  = 1'b1;
    isjump = 1'b1;
    NPC    = 32'h0000_3400;
    #2;
    Reset = 1'b0;
    #1;
    check_reset_values("arst");
    @(posedge Clk);
    #1;
    check_reset_values("arst_hold");
    model_reset();
    Reset = 1'b1;
    step("post_rst", 0, 0, 0, 32'h0);
    check_eq("post_rst_instr", Instr_D, 32'h2408_0001);
    check_eq("post_rst_pcf",   PC_F,    32'h0000_3004);
    step("post_rst1", 0, 0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/part_f.md
PART_F -- requirements
Module: part_f

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter IM_WORDS, default 4096, meaning the instruction memory depth in 32-bit words.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Stall, input, 1, hazard-unit hold of PC and F/D register.
REQ-006 SHALL have port FlushD, input, 1, which loads a bubble into the F/D register.
REQ-007 SHALL have port isjump, input, 1, meaning the decode stage selects a branch or jump target this cycle.
REQ-008 SHALL have port NPC, input, 32, the branch/jump target computed by decode.
REQ-009 SHALL have port IM_addr, output, 32, equal to PC_F, the fetch address to the instruction memory.
REQ-010 SHALL have port IM_rdata, input, 32, the combinational instruction memory read data for IM_addr.
REQ-011 SHALL have port PC_F, output, 32, the current fetch PC.
REQ-012 SHALL have port Instr_D, output, 32, the instruction registered for decode.
REQ-013 SHALL have port PC_D, output, 32, the PC of Instr_D.
REQ-014 SHALL have port PC4D, output, 32, equal to PC_D+4.
REQ-015 SHALL have port V_D, output, 1, the valid bit of the F/D entry.
REQ-016 SHALL have port ExcAdEL_D, output, 1, the fetch address-error flag of the F/D entry.
REQ-017 SHALL have port StallCnt, output, 32, the count of stalled cycles.

Function
REQ-018 SHALL compute next PC as Stall ? PC_F : (isjump ? NPC : PC_F+4); 32-bit wrap, no overflow detection.
REQ-019 SHALL update the F/D register as follows: FlushD loads a bubble (Instr 0, V_D 0, ExcAdEL_D 0, PC_D=PC_F); else Stall holds; else capture {instruction, PC_F, 1, error}.
REQ-020 SHALL give FlushD priority over Stall for the F/D register; PC SHALL still hold while Stall=1.
REQ-021 SHALL flag a fetch error when PC_F[1:0]!=0 or PC_F is outside [PC_RESET, PC_RESET+4*IM_WORDS).
REQ-022 SHALL, on a fetch error, capture Instr 32'h0 (nop) instead of IM_rdata and set ExcAdEL_D=1.
REQ-023 SHALL give fetch-to-decode latency of exactly 1 cycle when Stall=0 and FlushD=0.
REQ-024 SHALL support branch delay slot: the instruction at PC_F when isjump=1 is captured normally (not flushed).
REQ-025 SHALL increment StallCnt once per cycle with Stall=1 and saturate at 32'hFFFF_FFFF.
REQ-026 SHALL not feed IM_rdata combinationally to any output other than through the F/D register.

Reset
REQ-027 SHALL, on Reset=0 regardless of Clk, set PC_F=PC_RESET, Instr_D=0, PC_D=PC_RESET, V_D=0, ExcAdEL_D=0, StallCnt=0.
REQ-028 SHALL, when reset asserts mid-stall or mid-jump, discard the pending NPC or stall state with no residual effect after release.
REQ-029 SHALL, on the first rising edge after Reset deasserts, capture IM_rdata at PC_RESET into F/D and advance PC_F to PC_RESET+4.

Structure
REQ-030 SHALL place PC_RESET, IM_WORDS, the NOP encoding (32'h0) and the word width constant in the shared CPU package.
REQ-031 SHALL implement the F/D pipeline register as one sub-module, pipe_fd, holding Instr, PC, V and ExcAdEL with hold and clear controls; the PC register and next-PC logic stay in part_f.

Verification
REQ-032 SHALL cover sequential fetch: release reset, IM returns 32'h2408_0001 at 0x3000 -> after edge 1 Instr_D=32'h2408_0001, PC_D=0x3000, PC4D=0x3004, PC_F=0x3004, V_D=1.
REQ-033 SHALL cover jump: isjump=1, NPC=0x3100 at PC_F=0x3008 -> next edge PC_D=0x3008 (delay slot kept), PC_F=0x3100.
REQ-034 SHALL cover stall: Stall=1 for 3 cycles at PC_F=0x3010 -> PC_F and Instr_D unchanged for 3 cycles, StallCnt=3; isjump during stall ignored.
REQ-035 SHALL cover flush with stall: Stall=1 and FlushD=1 together -> Instr_D=0, V_D=0, PC_F held.
REQ-036 SHALL cover address error: NPC=0x3002 taken, then PC_F=0x3002 -> next edge Instr_D=0, ExcAdEL_D=1; same for NPC=0x0000_2FFC.
REQ-037 SHALL cover asynchronous reset: Reset=0 pulse between clock edges mid-run -> outputs reach the reset values immediately, before the next Clk edge.
